// File: rtl/trigger_pkg.sv
// Shared constants, FSM state type and small helpers for the trigger LUT sequencer.
package trigger_pkg;

  localparam int NUM_STAGES = 4;
  localparam int LUT_DEPTH  = 16;
  localparam int LUT_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_LUTS   = DATA_W / 4;
  localparam int SEL_W      = $clog2(NUM_STAGES);

  localparam logic [LUT_ADDR_W-1:0] LAST_COUNT = LUT_ADDR_W'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [SEL_W-1:0] idx);
    return {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Scan downwards so the lowest set bit is the last one to win.
  function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_STAGES-1:0] req);
    logic [SEL_W-1:0] idx;
    idx = {SEL_W{1'b0}};
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      idx = req[i] ? SEL_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/trigger_lut_sequencer_lut_word_gen.sv
// Combinational LUT word generator: one output bit per 4-input LUT for a given address.
module lut_word_gen
  import trigger_pkg::*;
(
  input  logic [LUT_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     mask,
  input  logic [DATA_W-1:0]     value,
  output logic [NUM_LUTS-1:0]   lut_din
);

  // A LUT entry matches when every unmasked input bit equals the programmed value bit.
  always_comb begin
    lut_din = {NUM_LUTS{1'b0}};
    for (int k = 0; k < NUM_LUTS; k++) begin
      lut_din[k] = ~|((addr ^ value[LUT_ADDR_W*k +: LUT_ADDR_W]) & mask[LUT_ADDR_W*k +: LUT_ADDR_W]);
    end
  end

endmodule

// File: rtl/trigger_lut_sequencer.sv
// Latches per-stage mask/value configuration and serially loads each stage's match LUTs,
// one stage at a time, lowest pending stage first.
module trigger_lut_sequencer
  import trigger_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_STAGES-1:0] wr_mask,
  input  logic [NUM_STAGES-1:0] wr_value,
  input  logic [DATA_W-1:0]     config_data,
  output logic [NUM_STAGES-1:0] lut_wrenb,
  output logic [NUM_LUTS-1:0]   lut_din,
  output logic                  busy,
  output logic [NUM_STAGES-1:0] load_done
);

  state_e                           state_q, state_d;
  logic [NUM_STAGES-1:0][DATA_W-1:0] mask_q, mask_d;
  logic [NUM_STAGES-1:0][DATA_W-1:0] value_q, value_d;
  logic [NUM_STAGES-1:0]            pending_q, pending_d;
  logic [SEL_W-1:0]                 sel_q, sel_d;
  logic [DATA_W-1:0]                wm_q, wm_d;
  logic [DATA_W-1:0]                wv_q, wv_d;
  logic [LUT_ADDR_W-1:0]            count_q, count_d;
  logic [NUM_STAGES-1:0]            lut_wrenb_q, lut_wrenb_d;
  logic [NUM_LUTS-1:0]              lut_din_q, lut_din_d;
  logic                             busy_q, busy_d;
  logic [NUM_STAGES-1:0]            load_done_q, load_done_d;

  logic [SEL_W-1:0]      grant_sel_s;
  logic [NUM_STAGES-1:0] grant_clr_s;
  logic [LUT_ADDR_W-1:0] gen_addr_s;
  logic [DATA_W-1:0]     gen_mask_s;
  logic [DATA_W-1:0]     gen_value_s;
  logic [NUM_LUTS-1:0]   gen_din_s;

  assign grant_sel_s = lowest_index(pending_q);

  assign lut_wrenb = lut_wrenb_q;
  assign lut_din   = lut_din_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

  lut_word_gen u_lut_word_gen (
    .addr    (gen_addr_s),
    .mask    (gen_mask_s),
    .value   (gen_value_s),
    .lut_din (gen_din_s)
  );

  // Configuration register writes from the command decoder strobes.
  always_comb begin
    mask_d  = mask_q;
    value_d = value_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (wr_mask[i]) begin
        mask_d[i] = config_data;
      end else begin
        mask_d[i] = mask_q[i];
      end
      if (wr_value[i]) begin
        value_d[i] = config_data;
      end else begin
        value_d[i] = value_q[i];
      end
    end
  end

  // Pending requests: a new value write wins over the grant clearing the same stage.
  always_comb begin
    grant_clr_s = {NUM_STAGES{1'b0}};
    if (state_q == GRANT) begin
      grant_clr_s = stage_onehot(grant_sel_s);
    end else begin
      grant_clr_s = {NUM_STAGES{1'b0}};
    end
    pending_d = (pending_q & ~grant_clr_s) | wr_value;
  end

  // Sequencer FSM; outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wm_d        = wm_q;
    wv_d        = wv_q;
    count_d     = count_q;
    lut_wrenb_d = {NUM_STAGES{1'b0}};
    lut_din_d   = {NUM_LUTS{1'b0}};
    load_done_d = {NUM_STAGES{1'b0}};
    gen_addr_s  = LAST_COUNT - count_q - 4'd1;
    gen_mask_s  = wm_q;
    gen_value_s = wv_q;

    case (state_q)
      IDLE: begin
        state_d = (pending_d != {NUM_STAGES{1'b0}}) ? GRANT : IDLE;
      end
      GRANT: begin
        sel_d       = grant_sel_s;
        wm_d        = mask_q[grant_sel_s];
        wv_d        = value_q[grant_sel_s];
        count_d     = {LUT_ADDR_W{1'b0}};
        gen_addr_s  = LAST_COUNT;
        gen_mask_s  = mask_q[grant_sel_s];
        gen_value_s = value_q[grant_sel_s];
        lut_wrenb_d = stage_onehot(grant_sel_s);
        lut_din_d   = gen_din_s;
        state_d     = LOAD;
      end
      LOAD: begin
        if (count_q == LAST_COUNT) begin
          count_d     = {LUT_ADDR_W{1'b0}};
          load_done_d = stage_onehot(sel_q);
          // Going straight to GRANT keeps back-to-back loads one cycle apart.
          state_d     = (pending_d != {NUM_STAGES{1'b0}}) ? GRANT : IDLE;
        end else begin
          count_d     = count_q + 4'd1;
          lut_wrenb_d = stage_onehot(sel_q);
          lut_din_d   = gen_din_s;
          state_d     = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (pending_d != {NUM_STAGES{1'b0}}) || (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mask_q      <= {(NUM_STAGES*DATA_W){1'b0}};
      value_q     <= {(NUM_STAGES*DATA_W){1'b0}};
      pending_q   <= {NUM_STAGES{1'b0}};
      sel_q       <= {SEL_W{1'b0}};
      wm_q        <= {DATA_W{1'b0}};
      wv_q        <= {DATA_W{1'b0}};
      count_q     <= {LUT_ADDR_W{1'b0}};
      lut_wrenb_q <= {NUM_STAGES{1'b0}};
      lut_din_q   <= {NUM_LUTS{1'b0}};
      busy_q      <= 1'b0;
      load_done_q <= {NUM_STAGES{1'b0}};
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      wm_q        <= wm_d;
      wv_q        <= wv_d;
      count_q     <= count_d;
      lut_wrenb_q <= lut_wrenb_d;
      lut_din_q   <= lut_din_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
    end
  end

endmodule
